// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the NMI arbiters: bus widths, FSM state, default error data.
package nmi_arb_pkg;

  localparam int NMI_AW = 32;
  localparam int NMI_DW = 32;
  localparam int NMI_SW = 4;

  localparam logic [NMI_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/nmi_rr_arbiter_if.sv
// NMI arbiter bundle: N master request ports, the shared slave port, and debug outputs.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface nmi_rr_arbiter_if
  import nmi_arb_pkg::*;
#(
  parameter int N_MST = 2
) ();

  logic [N_MST-1:0]        m_valid_i;
  logic [N_MST*NMI_AW-1:0] m_addr_i;
  logic [N_MST*NMI_DW-1:0] m_wdata_i;
  logic [N_MST*NMI_SW-1:0] m_wstrb_i;
  logic [NMI_DW-1:0]       m_rdata_o;
  logic [N_MST-1:0]        m_ready_o;

  logic                    s_valid_o;
  logic [NMI_AW-1:0]       s_addr_o;
  logic [NMI_DW-1:0]       s_wdata_o;
  logic [NMI_SW-1:0]       s_wstrb_o;
  logic [NMI_DW-1:0]       s_rdata_i;
  logic                    s_ready_i;

  logic [N_MST-1:0]        gnt_o;
  logic                    timeout_o;

  modport slave (
    input  m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_rdata_i, s_ready_i,
    output m_rdata_o, m_ready_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o,
           gnt_o, timeout_o
  );

  modport master (
    output m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_rdata_i, s_ready_i,
    input  m_rdata_o, m_ready_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o,
           gnt_o, timeout_o
  );

endinterface

// File: rtl/nmi_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo N_MST.
module nmi_rr_pick #(
  parameter int N_MST = 2,
  parameter int IW    = $clog2(N_MST)
) (
  input  logic [N_MST-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_MST-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  localparam logic [IW:0] N_W = (IW+1)'(N_MST);

  logic [2*N_MST-1:0] dbl;
  logic [N_MST-1:0]   rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;
  logic               found;

  // Rotate so the pointer position lands at bit 0; the first set bit is then the offset.
  always_comb begin
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[N_MST-1:0];
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N_MST; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    idx_o = sum[IW-1:0];
    any_o = |req_i;
    gnt_o = any_o ? (N_MST'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/nmi_rr_arbiter.sv
// Round-robin arbiter sharing one NMI slave among N_MST masters, grant held until slave ready,
// with a watchdog that completes hung transactions with an error response.
module nmi_rr_arbiter
  import nmi_arb_pkg::*;
#(
  parameter int               N_MST     = 2,
  parameter logic [15:0]      TIMEOUT   = 16'd1024,
  parameter logic [NMI_DW-1:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input logic             clk_i,
  input logic             rst_i,
  nmi_rr_arbiter_if.slave bus
);

  localparam int            IW       = $clog2(N_MST);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_MST-1);

  arb_state_e       state_q;
  logic [N_MST-1:0] gnt_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [15:0]      wdog_q;

  logic [IW-1:0]    rr_ptr_d;
  logic [15:0]      wdog_d;
  logic [N_MST-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             owner_valid;
  logic             in_busy;
  logic             in_err;
  logic             complete;
  logic             expire;

  nmi_rr_pick #(
    .N_MST (N_MST),
    .IW    (IW)
  ) u_pick (
    .req_i (bus.m_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // A granted master dropping valid is an abort; it outranks both completion and timeout.
  assign owner_valid = |(bus.m_valid_i & gnt_q);
  assign in_busy     = (state_q == BUSY);
  assign in_err      = (state_q == ERR);
  assign complete    = in_busy && owner_valid && bus.s_ready_i;
  assign expire      = in_busy && owner_valid && !bus.s_ready_i &&
                       (TIMEOUT != 16'd0) && (wdog_q == TIMEOUT - 16'd1);
  assign rr_ptr_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
  assign wdog_d      = wdog_q + 16'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wdog_q <= '0;
          if (pick_any) begin
            gnt_q   <= pick_gnt;
            idx_q   <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_valid) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            wdog_q  <= '0;
          end else if (complete) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= '0;
          end else if (expire) begin
            state_q <= ERR;
            wdog_q  <= '0;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        ERR: begin
          state_q  <= IDLE;
          gnt_q    <= '0;
          rr_ptr_q <= rr_ptr_d;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          wdog_q  <= '0;
        end
      endcase
    end
  end

  // Request mux is AND-OR on the one-hot grant, so no grant means an all-zero bus.
  logic [NMI_AW-1:0] s_addr;
  logic [NMI_DW-1:0] s_wdata;
  logic [NMI_SW-1:0] s_wstrb;

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    for (int i = 0; i < N_MST; i++) begin
      s_addr  = s_addr  | (bus.m_addr_i [i*NMI_AW +: NMI_AW] & {NMI_AW{gnt_q[i]}});
      s_wdata = s_wdata | (bus.m_wdata_i[i*NMI_DW +: NMI_DW] & {NMI_DW{gnt_q[i]}});
      s_wstrb = s_wstrb | (bus.m_wstrb_i[i*NMI_SW +: NMI_SW] & {NMI_SW{gnt_q[i]}});
    end
  end

  assign bus.s_valid_o = in_busy && owner_valid;
  assign bus.s_addr_o  = s_addr;
  assign bus.s_wdata_o = s_wdata;
  assign bus.s_wstrb_o = s_wstrb;
  assign bus.m_ready_o = (complete || in_err) ? gnt_q : '0;
  assign bus.m_rdata_o = in_err ? ERR_RDATA : bus.s_rdata_i;
  assign bus.gnt_o     = gnt_q;
  assign bus.timeout_o = in_err;

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Bench for nmi_rr_arbiter (3 masters, watchdog of 8): directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a transaction-level model.
module tb_nmi_rr_arbiter;
  import nmi_arb_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nmi_rr_arbiter_if #(.N_MST(N)) bus ();

  nmi_rr_arbiter #(
    .N_MST   (N),
    .TIMEOUT (16'(TMO))
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Stimulus state: what each master and the slave present this cycle.
  logic        v      [N];
  logic [31:0] a_addr [N];
  logic [31:0] a_wdata[N];
  logic [3:0]  a_wstrb[N];
  logic        s_ready;
  logic [31:0] s_rdata;

  // Model: who owns the bus, how long it has waited, who is being errored, next start point.
  int owner  = -1;
  int age    = 0;
  int eowner = -1;
  int ptr    = 0;

  logic [N-1:0] exp_ready_last;
  int           sv_cycles;
  int           rdy_cnt[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.m_valid_i[i]          = v[i];
      bus.m_addr_i[i*32 +: 32]  = a_addr[i];
      bus.m_wdata_i[i*32 +: 32] = a_wdata[i];
      bus.m_wstrb_i[i*4 +: 4]   = a_wstrb[i];
    end
    bus.s_ready_i = s_ready;
    bus.s_rdata_i = s_rdata;
  endtask

  task automatic model_reset();
    owner  = -1;
    age    = 0;
    eowner = -1;
    ptr    = 0;
  endtask

  task automatic model_update();
    if (eowner >= 0) begin
      ptr    = (eowner + 1) % N;
      eowner = -1;
    end else if (owner >= 0) begin
      if (!v[owner]) begin
        owner = -1;
      end else if (s_ready) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end else if (age == TMO - 1) begin
        eowner = owner;
        owner  = -1;
      end else begin
        age++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && v[(ptr + k) % N]) owner = (ptr + k) % N;
      end
      age = 0;
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_gnt;
    logic         e_sv;
    e_sv  = (owner >= 0) && v[owner];
    e_rdy = (e_sv && s_ready) ? onehot(owner) : onehot(eowner);
    e_gnt = (owner >= 0) ? onehot(owner) : onehot(eowner);
    chk("s_valid", 32'(bus.s_valid_o), 32'(e_sv));
    chk("m_ready", 32'(bus.m_ready_o), 32'(e_rdy));
    chk("gnt", 32'(bus.gnt_o), 32'(e_gnt));
    chk("timeout", 32'(bus.timeout_o), 32'(eowner >= 0));
    chk("m_rdata", bus.m_rdata_o, (eowner >= 0) ? 32'hDEAD_BEEF : s_rdata);
    if (e_sv) begin
      chk("s_addr", bus.s_addr_o, a_addr[owner]);
      chk("s_wdata", bus.s_wdata_o, a_wdata[owner]);
      chk("s_wstrb", 32'(bus.s_wstrb_o), 32'(a_wstrb[owner]));
    end
    exp_ready_last = e_rdy;
    if (bus.s_valid_o) sv_cycles++;
    for (int i = 0; i < N; i++) if (bus.m_ready_o[i]) rdy_cnt[i]++;
  endtask

  // Present inputs and check outputs mid-cycle; literal checks may follow before cyc_post.
  task automatic cyc_pre();
    drive();
    #1;
    compare();
  endtask

  task automatic cyc_post();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    s_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    model_reset();
    cyc_pre();
    cyc_post();
    rst = 1'b0;
  endtask

  logic [N-1:0] got[$];
  int           rdy0_before;

  initial begin
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0; a_wstrb[i] = '0; rdy_cnt[i] = 0;
    end
    s_ready = 1'b0;
    s_rdata = 32'h5A5A_0001;
    sv_cycles = 0;
    drive();
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state: everything zero while m_rdata_o follows s_rdata_i.
    cyc_pre();
    chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rst_svalid", 32'(bus.s_valid_o), 32'h0);
    chk("rst_saddr", bus.s_addr_o, 32'h0);
    chk("rst_rdata", bus.m_rdata_o, 32'h5A5A_0001);
    cyc_post();
    rst = 1'b0;

    // Single master read, slave ready on the 3rd BUSY cycle.
    v[0] = 1'b1; a_addr[0] = 32'h1000_0000; a_wstrb[0] = 4'h0;
    sv_cycles = 0; rdy_cnt[0] = 0;
    cyc_pre();
    chk("t1_idle_svalid", 32'(bus.s_valid_o), 32'h0);
    cyc_post();
    cyc_pre(); cyc_post();
    cyc_pre(); cyc_post();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    cyc_pre();
    chk("t1_ready", 32'(bus.m_ready_o), 32'h1);
    chk("t1_rdata", bus.m_rdata_o, 32'h1234_5678);
    cyc_post();
    idle_all();
    cyc_pre(); cyc_post();
    chk("t1_svalid_cycles", 32'(sv_cycles), 32'd3);
    chk("t1_ready_count", 32'(rdy_cnt[0]), 32'd1);

    // Contention: all three request continuously, 1-cycle slave.
    do_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; a_addr[i] = 32'h3000_0000 + 32'(i); a_wstrb[i] = 4'h0;
    end
    s_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 12; c++) begin
      cyc_pre();
      if (bus.m_ready_o != '0) got.push_back(bus.m_ready_o);
      cyc_post();
    end
    chk("t2_completions", 32'(got.size()), 32'd6);
    for (int k = 0; k < got.size(); k++) chk("t2_order", 32'(got[k]), 32'(onehot(k % N)));
    idle_all();

    // Write path through m1, m0 idle.
    v[1] = 1'b1; a_addr[1] = 32'h2000_0004; a_wdata[1] = 32'hCAFE_0001; a_wstrb[1] = 4'b0011;
    rdy0_before = rdy_cnt[0];
    cyc_pre(); cyc_post();
    for (int c = 0; c < 3; c++) begin
      s_ready = (c == 2);
      cyc_pre();
      chk("t3_addr", bus.s_addr_o, 32'h2000_0004);
      chk("t3_wdata", bus.s_wdata_o, 32'hCAFE_0001);
      chk("t3_wstrb", 32'(bus.s_wstrb_o), 32'h3);
      cyc_post();
    end
    idle_all();
    chk("t3_m0_not_readied", 32'(rdy_cnt[0]), 32'(rdy0_before));

    // Timeout: m2 granted (pointer is at 2), slave never answers, m0 waits behind it.
    v[2] = 1'b1; a_addr[2] = 32'h4000_0000; v[0] = 1'b1; a_addr[0] = 32'h4000_0100;
    cyc_pre(); cyc_post();
    sv_cycles = 0;
    for (int c = 0; c < TMO; c++) begin cyc_pre(); cyc_post(); end
    cyc_pre();
    chk("t4_err_ready", 32'(bus.m_ready_o), 32'h4);
    chk("t4_err_rdata", bus.m_rdata_o, 32'hDEAD_BEEF);
    chk("t4_timeout", 32'(bus.timeout_o), 32'h1);
    chk("t4_err_svalid", 32'(bus.s_valid_o), 32'h0);
    cyc_post();
    v[2] = 1'b0;
    chk("t4_svalid_cycles", 32'(sv_cycles), 32'd8);
    cyc_pre(); cyc_post();
    s_ready = 1'b1;
    cyc_pre();
    chk("t4_next_gnt", 32'(bus.gnt_o), 32'h1);
    cyc_post();
    idle_all();

    // Abort: m0 drops valid in its 2nd BUSY cycle, pointer stays at 0.
    do_reset();
    v[0] = 1'b1;
    cyc_pre(); cyc_post();
    cyc_pre(); cyc_post();
    v[0] = 1'b0;
    cyc_pre();
    chk("t5_abort_svalid", 32'(bus.s_valid_o), 32'h0);
    chk("t5_abort_ready", 32'(bus.m_ready_o), 32'h0);
    cyc_post();
    v[0] = 1'b1; v[1] = 1'b1;
    cyc_pre(); cyc_post();
    s_ready = 1'b1;
    cyc_pre();
    chk("t5_regrant", 32'(bus.gnt_o), 32'h1);
    cyc_post();
    v[0] = 1'b0;
    s_ready = 1'b0;
    cyc_pre(); cyc_post();
    s_ready = 1'b1;
    cyc_pre(); cyc_post();
    idle_all();

    // Reset in BUSY, stale ready afterwards, then normal traffic.
    v[0] = 1'b1;
    cyc_pre(); cyc_post();
    cyc_pre();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_svalid", 32'(bus.s_valid_o), 32'h0);
    chk("t6_rst_ready", 32'(bus.m_ready_o), 32'h0);
    chk("t6_rst_gnt", 32'(bus.gnt_o), 32'h0);
    cyc_post();
    rst = 1'b0;
    v[0] = 1'b0; s_ready = 1'b1;
    cyc_pre();
    chk("t6_stale_ready", 32'(bus.m_ready_o), 32'h0);
    cyc_post();
    s_ready = 1'b0; v[1] = 1'b1; a_addr[1] = 32'h5000_0000;
    cyc_pre(); cyc_post();
    s_ready = 1'b1;
    cyc_pre();
    chk("t6_after_ready", 32'(bus.m_ready_o), 32'h2);
    cyc_post();
    idle_all();

    // Randomized traffic with stalls, timeouts and occasional aborts.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom % 4) == 0) begin
          v[i] = 1'b1;
          a_addr[i] = $urandom; a_wdata[i] = $urandom; a_wstrb[i] = 4'($urandom);
        end
      end
      if (owner >= 0 && ($urandom % 40) == 0) v[owner] = 1'b0;
      s_ready = (($urandom % 10) < 3);
      s_rdata = $urandom;
      cyc_pre();
      cyc_post();
      for (int i = 0; i < N; i++) if (exp_ready_last[i]) v[i] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
